// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator sharing one prescaled counter.
// Each channel compares the shared counter against its own duty value.
// Duty values are double-buffered: writes land in a shadow register and are
// copied to the active register only when the counter wraps. This keeps
// every period glitch-free.
//
// Write port: single-cycle strobe with no back-pressure. Each cycle with
// wr_en=1 writes exactly one register, selected by wr_addr. The write is
// always accepted and takes effect at that rising edge.
//
// Address map:
//   0..NUM_CH-1 : duty shadow for channel addr
//   NUM_CH      : enable mask, taken from wr_data[NUM_CH-1:0]
//   NUM_CH+1    : prescale value P
//   other       : ignored
//
// Parameter constraints: 1 <= NUM_CH <= WIDTH, and 2**ADDR_W >= NUM_CH+2.

module pwm_bank #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam logic [WIDTH-1:0]  CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] ADDR_P    = ADDR_W'(NUM_CH + 1);

    logic [WIDTH-1:0]  duty_shadow [NUM_CH];
    logic [WIDTH-1:0]  duty_active [NUM_CH];
    logic [NUM_CH-1:0] enable;
    logic [WIDTH-1:0]  p_reg;
    logic [WIDTH-1:0]  pcnt;
    logic [WIDTH-1:0]  cnt;

    logic              mask_wr;
    logic              p_wr;
    logic [NUM_CH-1:0] duty_wr;
    logic              tick;
    logic              wrap;
    logic [NUM_CH-1:0] pwm_next;

    // Address decode: one-hot write enables for every register.
    always_comb begin
        mask_wr = wr_en && (wr_addr == ADDR_MASK);
        p_wr    = wr_en && (wr_addr == ADDR_P);
        duty_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_wr[i] = wr_en && (wr_addr == ADDR_W'(i));
        end
    end

    // Prescaler tick and end-of-period wrap. Both use the current register
    // values, so a write to P only changes behaviour from the next cycle on.
    always_comb begin
        tick = (pcnt == p_reg);
        wrap = tick && (cnt == CNT_MAX);
    end

    // Enable mask and prescale value registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable <= '0;
            p_reg  <= '0;
        end else begin
            if (mask_wr) begin
                enable <= wr_data[NUM_CH-1:0];
            end
            if (p_wr) begin
                p_reg <= wr_data;
            end
        end
    end

    // Prescaler and main counter. A write to P restarts the prescale count.
    // The main counter advances once per tick and wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt        <= '0;
            cnt         <= '0;
            period_tick <= 1'b0;
        end else begin
            if (p_wr || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            if (tick) begin
                cnt <= cnt + 1'b1;
            end
            period_tick <= wrap;
        end
    end

    // Duty double-buffer. At wrap, active takes the shadow value from before
    // the edge, so a write that coincides with a wrap applies one period later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_shadow[i] <= '0;
                duty_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (duty_wr[i]) begin
                    duty_shadow[i] <= wr_data;
                end
                if (wrap) begin
                    duty_active[i] <= duty_shadow[i];
                end
            end
        end
    end

    // Per-channel compare. An all-ones duty forces the output constantly high.
    always_comb begin
        pwm_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_next[i] = enable[i] &&
                          ((duty_active[i] == CNT_MAX) || (cnt < duty_active[i]));
        end
    end

    // Registered PWM outputs. They lag the compared counter value by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= pwm_next;
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: bench for pwm_bank with NUM_CH=8, WIDTH=8, ADDR_W=4.
// Stimulus is driven and outputs are sampled on the falling clock edge.
// Expected values come from hand-derived constants: high-time counts and
// period lengths over one window. A window runs from a period_tick cycle
// (inclusive) to the next period_tick cycle (exclusive).

module tb_pwm_bank;

    localparam int NUM_CH = 8;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;
    localparam int BUDGET = 5000;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [WIDTH-1:0]  wr_data = '0;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_tick;

    always #5 clk = ~clk;

    pwm_bank #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic push_exp(input int v);
        exp_q.push_back(32'(v));
    endtask

    task automatic check_pop(input string name, input int actual);
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: got %0d, nothing expected in queue", name, actual);
        end else begin
            e = exp_q.pop_front();
            if (32'(actual) != e) begin
                n_errors++;
                $display("FAIL %s: got %0d, expected %0d", name, actual, e);
            end
        end
    endtask

    task automatic check_eq(input string name, input int actual, input int expected);
        push_exp(expected);
        check_pop(name, actual);
    endtask

    task automatic check_flag(input string name, input bit ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got timeout, expected period_tick within %0d cycles", name, BUDGET);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic apply_cfg(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] en,
                             input logic [7:0] p);
        wr(4'd0, d0);
        wr(4'd1, d1);
        wr(4'd2, d2);
        wr(4'd8, en);
        wr(4'd9, p);
    endtask

    // Advance to the next negedge at which period_tick is high.
    task automatic wait_tick();
        int n;
        @(negedge clk);
        n = 1;
        while (!period_tick && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check_flag("wait_tick", period_tick);
    endtask

    // Measure one window starting at a negedge where period_tick is high.
    // If wr_at >= 0, a single write (a, d) is driven during window cycle wr_at.
    int m_len, m_h0, m_h1, m_h2, m_hrest;
    bit m_ok;

    task automatic measure(input int wr_at, input logic [ADDR_W-1:0] a,
                           input logic [WIDTH-1:0] d);
        m_len = 0; m_h0 = 0; m_h1 = 0; m_h2 = 0; m_hrest = 0;
        do begin
            wr_en   = (m_len == wr_at);
            wr_addr = a;
            wr_data = d;
            if (pwm_out[0]) m_h0++;
            if (pwm_out[1]) m_h1++;
            if (pwm_out[2]) m_h2++;
            if (pwm_out[7:3] != 5'd0) m_hrest++;
            m_len++;
            @(negedge clk);
        end while (!period_tick && m_len < BUDGET);
        wr_en = 1'b0;
        m_ok  = period_tick;
        check_flag("window_end", m_ok);
    endtask

    // Reset for three cycles with writes in flight. Then check the release
    // latency and that the overridden writes left no trace.
    task automatic do_reset();
        int idx;
        int h;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            case (i)
                0:       begin wr_addr = 4'd9; wr_data = 8'($urandom_range(1, 255)); end
                1:       begin wr_addr = 4'd8; wr_data = 8'hFF; end
                default: begin wr_addr = 4'd0; wr_data = 8'($urandom_range(1, 254)); end
            endcase
            @(negedge clk);
            check_eq("rst_pwm_out", int'(pwm_out), 0);
            check_eq("rst_period_tick", int'(period_tick), 0);
        end
        wr_en = 1'b0;
        rst   = 1'b0;
        // This negedge lies in the first cycle after release (cycle 1).
        idx = 1;
        h   = 0;
        while (!period_tick && idx < BUDGET) begin
            if (pwm_out != '0) h++;
            @(negedge clk);
            idx++;
        end
        check_eq("first_tick_cycle", idx, 257);
        check_eq("release_pwm_high", h, 0);
        push_exp(256); push_exp(0); push_exp(0);
        measure(-1, 4'd0, 8'd0);
        check_pop("post_rst_len", m_len);
        check_pop("post_rst_h0", m_h0);
        check_pop("post_rst_hrest", m_hrest);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] d0, d1, d2, en, p;
        int         nper;
        int         exp_len, exp_h0, exp_h1, exp_h2;
    } vec_t;

    vec_t vecs[6];

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{8'h40, 8'h00, 8'h00, 8'h01, 8'h00, 2, 256,  64,   0,   0};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'h06, 8'h00, 3, 256,   0, 256,   0};
        vecs[2] = '{8'h80, 8'h00, 8'h00, 8'h01, 8'h03, 1, 1024, 512,  0,   0};
        vecs[3] = '{8'h01, 8'hFE, 8'hC0, 8'h07, 8'h01, 1, 512,    2, 508, 384};
        vecs[4] = '{8'hFF, 8'h40, 8'h80, 8'h05, 8'h00, 1, 256,  256,   0, 128};
        vecs[5] = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 1, 256,    0,   0,   0};

        // Reset with write activity, release latency.
        do_reset();

        // Steady-state duty/enable/prescale vectors.
        foreach (vecs[v]) begin
            apply_cfg(vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].en, vecs[v].p);
            wait_tick();
            wait_tick();
            for (int k = 0; k < vecs[v].nper; k++) begin
                push_exp(vecs[v].exp_len);
                push_exp(vecs[v].exp_h0);
                push_exp(vecs[v].exp_h1);
                push_exp(vecs[v].exp_h2);
                push_exp(0);
                measure(-1, 4'd0, 8'd0);
                check_pop("vec_len", m_len);
                check_pop("vec_h0", m_h0);
                check_pop("vec_h1", m_h1);
                check_pop("vec_h2", m_h2);
                check_pop("vec_hrest", m_hrest);
            end
        end

        // Double buffer: write 0xC0 at cnt=0x10, then 0x40 on the wrap edge.
        apply_cfg(8'h40, 8'h00, 8'h00, 8'h01, 8'h00);
        wait_tick();
        wait_tick();
        push_exp(256); push_exp(64);
        measure(16, 4'd0, 8'hC0);
        check_pop("dbuf_mid_len", m_len);
        check_pop("dbuf_mid_h0", m_h0);
        push_exp(256); push_exp(192);
        measure(-1, 4'd0, 8'd0);
        check_pop("dbuf_next_len", m_len);
        check_pop("dbuf_next_h0", m_h0);
        push_exp(256); push_exp(192);
        measure(255, 4'd0, 8'h40);
        check_pop("dbuf_wrapwr_len", m_len);
        check_pop("dbuf_wrapwr_h0", m_h0);
        push_exp(256); push_exp(192);
        measure(-1, 4'd0, 8'd0);
        check_pop("dbuf_held_len", m_len);
        check_pop("dbuf_held_h0", m_h0);
        push_exp(256); push_exp(64);
        measure(-1, 4'd0, 8'd0);
        check_pop("dbuf_applied_len", m_len);
        check_pop("dbuf_applied_h0", m_h0);

        // Prescaler: P=3, then P=0 written in window cycle 400 (cnt=100, pcnt=0).
        // The counter holds at 100 through cycle 401 and then steps every clock,
        // so the window is 557 cycles long. Channel 0 is high for cycles 0..428.
        apply_cfg(8'h80, 8'h00, 8'h00, 8'h01, 8'h03);
        wait_tick();
        wait_tick();
        push_exp(557); push_exp(429);
        measure(400, 4'd9, 8'h00);
        check_pop("p_change_len", m_len);
        check_pop("p_change_h0", m_h0);
        push_exp(256); push_exp(128);
        measure(-1, 4'd0, 8'd0);
        check_pop("p0_len", m_len);
        check_pop("p0_h0", m_h0);

        // Unmapped addresses change nothing.
        apply_cfg(8'h40, 8'h00, 8'h00, 8'h01, 8'h00);
        wait_tick();
        for (int a = 10; a < 16; a++) begin
            wr(4'(a), 8'hFF);
        end
        wait_tick();
        push_exp(256); push_exp(64); push_exp(0); push_exp(0); push_exp(0);
        measure(-1, 4'd0, 8'd0);
        check_pop("illegal_len", m_len);
        check_pop("illegal_h0", m_h0);
        check_pop("illegal_h1", m_h1);
        check_pop("illegal_h2", m_h2);
        check_pop("illegal_hrest", m_hrest);

        // Clear enable during window cycle 30. Output still high one clock
        // after the write edge, low from the second.
        for (int i = 0; i < 30; i++) @(negedge clk);
        wr(4'd8, 8'h00);
        check_eq("en_clear_plus1", int'(pwm_out[0]), 1);
        @(negedge clk);
        check_eq("en_clear_plus2", int'(pwm_out[0]), 0);

        // Reset mid-period aborts the period.
        apply_cfg(8'h40, 8'h00, 8'h00, 8'h01, 8'h00);
        wait_tick();
        wait_tick();
        for (int i = 0; i < 20; i++) @(negedge clk);
        do_reset();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time limit.
    initial begin
        #1000000;
        n_errors++;
        n_checks++;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
